// File: rtl/ifu_wide_pkg.sv
// Shared types for the wide fetch unit: fetch entries, packets, miss FSM.
// Width parameters live here because the packet structs depend on them.
package ifu_wide_pkg;
    localparam int ADDR_WIDTH  = 32;
    localparam int INSTR_WIDTH = 32;
    localparam int BLOCK_BITS  = 64;
    localparam int FETCH_WIDTH = 2;
    localparam int IPB         = BLOCK_BITS / INSTR_WIDTH;
    localparam int OFF_W       = $clog2(IPB);
    localparam int BLK_OFF_W   = $clog2(BLOCK_BITS / 8);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef logic [ADDR_WIDTH-1:0]  addr_t;
    typedef logic [INSTR_WIDTH-1:0] instr_t;
    typedef logic [BLOCK_BITS-1:0]  block_t;

    typedef struct packed {
        instr_t instr;
        addr_t  pc;
        logic   is_cond_br;
        logic   br_dir_pred;
        addr_t  br_target_pred;
    } ififo_entry_t;

    typedef struct packed {
        ififo_entry_t [FETCH_WIDTH-1:0] slot;
        logic [FETCH_WIDTH-1:0]         mask;
    } fetch_pkt_t;

    localparam int PKT_W = $bits(fetch_pkt_t);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} fsm_t;
endpackage

// File: rtl/ifu_wide_if.sv
// Bus bundles around the fetch unit: I$ lookup/refill, DRAM miss port,
// and the packet handshake towards dispatch.
interface ifu_icache_if;
    import ifu_wide_pkg::*;
    addr_t  icache_addr;
    logic   icache_hit;
    block_t icache_block;
    logic   icache_we;
    addr_t  icache_waddr;
    block_t icache_wdata;
    modport master (
        output icache_addr, icache_we, icache_waddr, icache_wdata,
        input  icache_hit, icache_block
    );
    modport slave (
        input  icache_addr, icache_we, icache_waddr, icache_wdata,
        output icache_hit, icache_block
    );
endinterface

interface ifu_dram_if;
    import ifu_wide_pkg::*;
    logic   dram_req_valid;
    logic   dram_req_ready;
    addr_t  dram_req_addr;
    logic   dram_resp_valid;
    block_t dram_resp_data;
    modport master (
        output dram_req_valid, dram_req_addr,
        input  dram_req_ready, dram_resp_valid, dram_resp_data
    );
    modport slave (
        input  dram_req_valid, dram_req_addr,
        output dram_req_ready, dram_resp_valid, dram_resp_data
    );
endinterface

interface ifu_pkt_if;
    import ifu_wide_pkg::*;
    logic       pkt_valid;
    logic       pkt_ready;
    fetch_pkt_t pkt_data;
    modport master (output pkt_valid, pkt_data, input pkt_ready);
    modport slave  (input pkt_valid, pkt_data, output pkt_ready);
endinterface

// File: rtl/ifu_wide_fifo.sv
// Circular packet queue; flush empties it, full blocks enqueue outright
// and a fresh entry only becomes visible at the output a cycle later.
module fifo #(
    parameter int ENTRY_WIDTH = 8,
    parameter int N_ENTRIES   = 8
) (
    input  logic                   clk,
    input  logic                   rst_aL,
    input  logic                   flush,
    input  logic                   enq,
    input  logic [ENTRY_WIDTH-1:0] enq_data,
    output logic                   full,
    input  logic                   deq,
    output logic                   valid,
    output logic [ENTRY_WIDTH-1:0] deq_data
);
    localparam int PW = $clog2(N_ENTRIES);

    logic [ENTRY_WIDTH-1:0] mem [N_ENTRIES];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [PW:0]            count;
    logic                   do_enq;
    logic                   do_deq;

    assign full     = count == (PW+1)'(N_ENTRIES);
    assign valid    = count != '0;
    assign deq_data = mem[rd_ptr];
    assign do_enq   = enq & ~full;
    assign do_deq   = deq & valid;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + 1'b1;
            if (do_deq) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_enq) - (PW+1)'(do_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq && !flush) mem[wr_ptr] <= enq_data;
    end
endmodule

// File: rtl/ifu_wide_predecode.sv
// One fetch slot: spots JAL / conditional branches and forms the
// static (backward-taken) prediction and its target.
module ifu_predecode
    import ifu_wide_pkg::*;
(
    input  instr_t instr,
    input  addr_t  pc,
    output logic   is_cond_br,
    output logic   taken,
    output addr_t  target
);
    logic  is_jal;
    addr_t imm_j;
    addr_t imm_b;

    assign is_jal     = instr[6:0] == OP_JAL;
    assign is_cond_br = instr[6:0] == OP_BRANCH;

    assign imm_j = {{(ADDR_WIDTH-20){instr[31]}}, instr[19:12],
                    instr[20], instr[30:21], 1'b0};
    assign imm_b = {{(ADDR_WIDTH-12){instr[31]}}, instr[7],
                    instr[30:25], instr[11:8], 1'b0};

    assign taken  = is_jal | (is_cond_br & instr[31]);
    assign target = pc + (is_jal ? imm_j : imm_b);
endmodule

// File: rtl/ifu_wide.sv
// Multi-issue fetch: PC, slot masking with static prediction, I$ miss
// handling towards DRAM, and the packet FIFO feeding dispatch.
module ifu_wide
    import ifu_wide_pkg::*;
#(
    parameter int    FIFO_DEPTH = 8,
    parameter addr_t RESET_PC   = '0
) (
    input  logic  clk,
    input  logic  rst_aL,
    input  addr_t recovery_PC,
    input  logic  recovery_PC_valid,
    input  logic  backend_stall,
    ifu_icache_if.master ic,
    ifu_dram_if.master   dram,
    ifu_pkt_if.master    pkt
);
    fsm_t   state;
    addr_t  pc;
    addr_t  req_addr;
    addr_t  npc;
    block_t wdata;
    logic   req_valid;
    logic   we;
    logic   fifo_full;
    logic   fire;
    logic   stop;

    logic [OFF_W-1:0]       off;
    instr_t                 blk_words [IPB];
    logic [OFF_W-1:0]       slot_idx  [FETCH_WIDTH];
    instr_t                 slot_instr [FETCH_WIDTH];
    addr_t                  slot_pc   [FETCH_WIDTH];
    addr_t                  slot_tgt  [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] in_blk;
    logic [FETCH_WIDTH-1:0] is_br;
    logic [FETCH_WIDTH-1:0] taken;
    logic [FETCH_WIDTH-1:0] mask;
    fetch_pkt_t             pkt_in;

    assign off = pc[2 +: OFF_W];

    for (genvar w = 0; w < IPB; w++) begin : g_word
        assign blk_words[w] = ic.icache_block[w*INSTR_WIDTH +: INSTR_WIDTH];
    end

    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
        assign slot_pc[i]    = pc + addr_t'(4 * i);
        assign slot_idx[i]   = off + OFF_W'(i);
        assign in_blk[i]     = ({1'b0, off} + (OFF_W+1)'(i)) < (OFF_W+1)'(IPB);
        assign slot_instr[i] = blk_words[slot_idx[i]];
        ifu_predecode u_pd (
            .instr      (slot_instr[i]),
            .pc         (slot_pc[i]),
            .is_cond_br (is_br[i]),
            .taken      (taken[i]),
            .target     (slot_tgt[i])
        );
    end

    // Slots past the block end or after a predicted-taken slot are dropped
    always_comb begin
        stop   = 1'b0;
        npc    = pc;
        mask   = '0;
        pkt_in = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (in_blk[i] && !stop) begin
                mask[i] = 1'b1;
                stop    = taken[i];
                npc     = taken[i] ? slot_tgt[i] : slot_pc[i] + addr_t'(4);
                pkt_in.slot[i].instr          = slot_instr[i];
                pkt_in.slot[i].pc             = slot_pc[i];
                pkt_in.slot[i].is_cond_br     = is_br[i];
                pkt_in.slot[i].br_dir_pred    = taken[i];
                pkt_in.slot[i].br_target_pred = npc;
            end
        end
        pkt_in.mask = mask;
    end

    // The refill write lands at the end of the we cycle, so that lookup is ignored
    assign fire = (state == IDLE) & ~we & ic.icache_hit & ~fifo_full
                & ~backend_stall & ~recovery_PC_valid;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_valid <= 1'b0;
            req_addr  <= '0;
            we        <= 1'b0;
            wdata     <= '0;
        end else begin
            we <= 1'b0;
            if (recovery_PC_valid) pc <= recovery_PC;
            else if (fire)         pc <= npc;
            if ((state == WAIT || state == DRAIN) && dram.dram_resp_valid) begin
                we    <= 1'b1;
                wdata <= dram.dram_resp_data;
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (!recovery_PC_valid && !we && !ic.icache_hit) begin
                            state     <= REQ;
                            req_valid <= 1'b1;
                            req_addr  <= {pc[ADDR_WIDTH-1:BLK_OFF_W], BLK_OFF_W'(0)};
                        end
                    end
                    REQ: begin
                        if (dram.dram_req_ready) begin
                            req_valid <= 1'b0;
                            state     <= recovery_PC_valid ? DRAIN : WAIT;
                        end else if (recovery_PC_valid) begin
                            req_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    WAIT: begin
                        if (recovery_PC_valid) state <= DRAIN;
                    end
                    DRAIN: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ic.icache_addr    = pc;
    assign ic.icache_we      = we;
    assign ic.icache_waddr   = req_addr;
    assign ic.icache_wdata   = wdata;
    assign dram.dram_req_valid = req_valid;
    assign dram.dram_req_addr  = req_addr;

    fifo #(
        .ENTRY_WIDTH (PKT_W),
        .N_ENTRIES   (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_aL   (rst_aL),
        .flush    (recovery_PC_valid),
        .enq      (fire),
        .enq_data (pkt_in),
        .full     (fifo_full),
        .deq      (pkt.pkt_ready),
        .valid    (pkt.pkt_valid),
        .deq_data (pkt.pkt_data)
    );
endmodule

// File: tb/tb_ifu_wide.sv
// Random-stimulus bench for ifu_wide: a memory image, an I$ and DRAM
// environment, and a queue-based reference model of fetch behaviour.
module tb_ifu_wide;
    import ifu_wide_pkg::*;

    localparam int DEPTH     = 8;
    localparam int BLK_BYTES = BLOCK_BITS / 8;
    localparam int M_IDLE  = 0;
    localparam int M_REQ   = 1;
    localparam int M_WAIT  = 2;
    localparam int M_DRAIN = 3;

    typedef enum int {K_ALU, K_BR, K_JAL} kind_t;

    logic  clk = 1'b0;
    logic  rst_aL;
    addr_t recovery_PC;
    logic  recovery_PC_valid;
    logic  backend_stall;

    ifu_icache_if ic ();
    ifu_dram_if   dram ();
    ifu_pkt_if    pkt ();

    ifu_wide #(
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk               (clk),
        .rst_aL            (rst_aL),
        .recovery_PC       (recovery_PC),
        .recovery_PC_valid (recovery_PC_valid),
        .backend_stall     (backend_stall),
        .ic                (ic),
        .dram              (dram),
        .pkt               (pkt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_deq  = 0;
    int n_fill = 0;

    task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    instr_t mem_word [addr_t];
    kind_t  mem_kind [addr_t];
    int     mem_imm  [addr_t];
    block_t icache_mem [addr_t];

    function automatic instr_t enc(kind_t k, int imm);
        logic [20:0] v;
        v = 21'(imm);
        case (k)
            K_BR:    return {v[12], v[10:5], 5'd2, 5'd1, 3'b000, v[4:1], v[11], OP_BRANCH};
            K_JAL:   return {v[20], v[10:1], v[11], v[19:12], 5'd1, OP_JAL};
            default: return {12'(imm), 5'd0, 3'b000, 5'd1, 7'b0010011};
        endcase
    endfunction

    function automatic void put(addr_t a, kind_t k, int imm);
        mem_kind[a] = k;
        mem_imm[a]  = imm;
        mem_word[a] = enc(k, imm);
    endfunction

    function automatic void touch(addr_t a);
        int r;
        if (mem_word.exists(a) != 0) return;
        r = int'($urandom_range(99));
        if (r < 60)      put(a, K_ALU, int'($urandom_range(2047)));
        else if (r < 85) put(a, K_BR, 4 * int'($urandom_range(16)) - 32);
        else             put(a, K_JAL, 4 * int'($urandom_range(32)) - 64);
    endfunction

    function automatic addr_t blk_base(addr_t a);
        return a - (a % BLK_BYTES);
    endfunction

    function automatic block_t block_of(addr_t a);
        block_t b;
        addr_t  base;
        base = blk_base(a);
        b = '0;
        for (int w = 0; w < IPB; w++) begin
            touch(base + addr_t'(4 * w));
            b[w*INSTR_WIDTH +: INSTR_WIDTH] = mem_word[base + addr_t'(4 * w)];
        end
        return b;
    endfunction

    // Expected packet straight from the memory image's instruction kinds
    function automatic fetch_pkt_t model_pkt(input addr_t pc, output addr_t nxt);
        fetch_pkt_t p;
        int    off, n;
        addr_t a, tgt;
        bit    dir, hit_taken;
        p = '0;
        n = 0;
        hit_taken = 0;
        tgt = '0;
        off = int'((pc % BLK_BYTES) / 4);
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (off + i >= IPB || hit_taken) break;
            a = pc + addr_t'(4 * i);
            touch(a);
            dir = mem_kind[a] == K_JAL || (mem_kind[a] == K_BR && mem_imm[a] < 0);
            p.mask[i] = 1'b1;
            p.slot[i].instr          = mem_word[a];
            p.slot[i].pc             = a;
            p.slot[i].is_cond_br     = mem_kind[a] == K_BR;
            p.slot[i].br_dir_pred    = dir;
            p.slot[i].br_target_pred = dir ? a + addr_t'(mem_imm[a]) : a + 4;
            n++;
            if (dir) begin
                hit_taken = 1;
                tgt = a + addr_t'(mem_imm[a]);
            end
        end
        nxt = hit_taken ? tgt : pc + addr_t'(4 * n);
        return p;
    endfunction

    addr_t      m_pc, m_req_addr;
    int         m_mode;
    bit         m_we;
    block_t     m_wdata;
    fetch_pkt_t q [$];

    bit    d_busy;
    addr_t d_addr;
    int    d_delay;

    function automatic void model_reset();
        q.delete();
        m_pc = '0;
        m_mode = M_IDLE;
        m_we = 0;
        m_req_addr = '0;
        m_wdata = '0;
        d_busy = 0;
    endfunction

    task automatic compare();
        check("icache_addr", ic.icache_addr, m_pc);
        check("pkt_valid", pkt.pkt_valid, q.size() != 0);
        if (q.size() != 0) check("pkt_data", pkt.pkt_data, q[0]);
        check("req_valid", dram.dram_req_valid, m_mode == M_REQ);
        if (m_mode == M_REQ) check("req_addr", dram.dram_req_addr, m_req_addr);
        check("icache_we", ic.icache_we, m_we);
        if (m_we) begin
            check("icache_waddr", ic.icache_waddr, m_req_addr);
            check("icache_wdata", ic.icache_wdata, m_wdata);
        end
    endtask

    task automatic step_cycle(int p_ready, int p_stall, int p_rec);
        bit         was_busy, resp, hit, full, deq, fire, rdy;
        block_t     rdata;
        fetch_pkt_t p;
        addr_t      nxt;
        compare();
        was_busy = d_busy;
        resp = 0;
        rdata = {$urandom, $urandom};
        if (d_busy) begin
            if (d_delay == 0) begin
                resp = 1;
                rdata = block_of(d_addr);
                d_busy = 0;
            end else d_delay--;
        end
        dram.dram_resp_valid = resp;
        dram.dram_resp_data  = rdata;
        rdy = !was_busy && ($urandom_range(99) < 50);
        dram.dram_req_ready = rdy;
        if (dram.dram_req_valid && rdy) begin
            d_busy  = 1;
            d_addr  = dram.dram_req_addr;
            d_delay = int'($urandom_range(3));
        end
        hit = icache_mem.exists(blk_base(ic.icache_addr)) != 0;
        ic.icache_hit   = hit;
        ic.icache_block = hit ? icache_mem[blk_base(ic.icache_addr)] : {$urandom, $urandom};
        pkt.pkt_ready     = $urandom_range(99) < p_ready;
        backend_stall     = $urandom_range(99) < p_stall;
        recovery_PC_valid = $urandom_range(99) < p_rec;
        if ($urandom_range(7) == 0) recovery_PC = 32'hFFFF_FFF8 + addr_t'(4 * $urandom_range(1));
        else                        recovery_PC = addr_t'(4 * $urandom_range(63));

        full = q.size() == DEPTH;
        deq  = q.size() != 0 && pkt.pkt_ready;
        fire = m_mode == M_IDLE && !m_we && hit && !full && !backend_stall && !recovery_PC_valid;
        nxt  = m_pc;
        p    = '0;
        if (fire) p = model_pkt(m_pc, nxt);
        if (deq) n_deq++;
        if (recovery_PC_valid) q.delete();
        else begin
            if (deq) void'(q.pop_front());
            if (fire) q.push_back(p);
        end
        m_we = 0;
        if ((m_mode == M_WAIT || m_mode == M_DRAIN) && resp) begin
            m_we = 1;
            m_wdata = rdata;
            m_mode = M_IDLE;
            n_fill++;
        end else if (recovery_PC_valid) begin
            if (m_mode == M_REQ) m_mode = rdy ? M_DRAIN : M_IDLE;
            else if (m_mode == M_WAIT) m_mode = M_DRAIN;
        end else if (m_mode == M_IDLE && !hit && !was_we_cycle()) begin
            m_mode = M_REQ;
            m_req_addr = blk_base(m_pc);
        end else if (m_mode == M_REQ && rdy) begin
            m_mode = M_WAIT;
        end
        if (recovery_PC_valid) m_pc = recovery_PC;
        else if (fire) m_pc = nxt;
        prev_we = m_we;
    endtask

    bit prev_we = 0;
    bit cur_we  = 0;
    function automatic bit was_we_cycle();
        return cur_we;
    endfunction

    task automatic do_cycle(int p_ready, int p_stall, int p_rec);
        @(negedge clk);
        cur_we = prev_we;
        step_cycle(p_ready, p_stall, p_rec);
    endtask

    always @(posedge clk) begin
        if (rst_aL && ic.icache_we) icache_mem[ic.icache_waddr] = ic.icache_wdata;
    end

    initial begin
        rst_aL = 1'b0;
        recovery_PC = '0;
        recovery_PC_valid = 1'b0;
        backend_stall = 1'b0;
        pkt.pkt_ready = 1'b0;
        ic.icache_hit = 1'b0;
        ic.icache_block = '0;
        dram.dram_req_ready = 1'b0;
        dram.dram_resp_valid = 1'b0;
        dram.dram_resp_data = '0;
        put(32'h0, K_ALU, 1);
        put(32'h4, K_ALU, 2);
        put(32'h10, K_BR, -8);
        for (int b = 0; b < 8; b++) icache_mem[addr_t'(b * BLK_BYTES)] = block_of(addr_t'(b * BLK_BYTES));
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_pkt_valid", pkt.pkt_valid, 1'b0);
        check("rst_req_valid", dram.dram_req_valid, 1'b0);
        check("rst_icache_we", ic.icache_we, 1'b0);
        check("rst_pc", ic.icache_addr, 32'h0);
        rst_aL = 1'b1;
        cur_we = 0;
        step_cycle(80, 0, 0);
        repeat (600) do_cycle(80, 5, 2);
        repeat (600) do_cycle(10, 5, 1);
        repeat (600) do_cycle(90, 0, 4);
        for (int i = 0; i < 300; i++) begin
            do_cycle(50, 0, 0);
            if (m_mode != M_IDLE) break;
        end
        #2 rst_aL = 1'b0;
        recovery_PC_valid = 1'b0;
        dram.dram_resp_valid = 1'b0;
        #1;
        check("mid_rst_req_valid", dram.dram_req_valid, 1'b0);
        check("mid_rst_pkt_valid", pkt.pkt_valid, 1'b0);
        check("mid_rst_icache_we", ic.icache_we, 1'b0);
        check("mid_rst_pc", ic.icache_addr, 32'h0);
        model_reset();
        prev_we = 0;
        @(negedge clk);
        rst_aL = 1'b1;
        cur_we = 0;
        step_cycle(70, 5, 2);
        repeat (300) do_cycle(70, 5, 2);
        check("progress", n_deq > 20, 1'b1);
        check("refills", n_fill > 0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
